// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// One operation in flight: accept (IDLE), execute (EXEC), return result (RESP).
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNC3_WIDTH = 3,
  parameter int FUNC7_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_WIDTH-1:0]  req0_a,
  input  logic [DATA_WIDTH-1:0]  req0_b,
  input  logic [FUNC3_WIDTH-1:0] req0_func3,
  input  logic [FUNC7_WIDTH-1:0] req0_func7,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req1_a,
  input  logic [DATA_WIDTH-1:0]  req1_b,
  input  logic [FUNC3_WIDTH-1:0] req1_func3,
  input  logic [FUNC7_WIDTH-1:0] req1_func7,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [DATA_WIDTH-1:0]  rsp0_data,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [DATA_WIDTH-1:0]  rsp1_data,
  output logic [DATA_WIDTH-1:0]  alu_bus_A,
  output logic [DATA_WIDTH-1:0]  alu_bus_B,
  output logic [FUNC3_WIDTH-1:0] alu_func3,
  output logic [FUNC7_WIDTH-1:0] alu_func7,
  input  logic [DATA_WIDTH-1:0]  alu_bus_out,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   owner_q, owner_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [FUNC3_WIDTH-1:0] func3_q, func3_d;
  logic [FUNC7_WIDTH-1:0] func7_q, func7_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;

  logic any_valid_s;
  logic winner_s;

  // On contention the requester that did not win last time is chosen.
  assign any_valid_s = req0_valid | req1_valid;
  assign winner_s    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  assign alu_bus_A = a_q;
  assign alu_bus_B = b_q;
  assign alu_func3 = func3_q;
  assign alu_func7 = func7_q;
  assign rsp0_data = result_q;
  assign rsp1_data = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      func3_q      <= '0;
      func7_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      func3_q      <= func3_d;
      func7_q      <= func7_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    func3_d      = func3_q;
    func7_d      = func7_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (any_valid_s) begin
          state_d      = EXEC;
          owner_d      = winner_s;
          last_grant_d = winner_s;
          if (winner_s) begin
            a_d     = req1_a;
            b_d     = req1_b;
            func3_d = req1_func3;
            func7_d = req1_func7;
          end else begin
            a_d     = req0_a;
            b_d     = req0_b;
            func3_d = req0_func3;
            func7_d = req0_func7;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_bus_out;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid & ~winner_s;
        req1_ready = req1_valid & winner_s;
      end
      EXEC: begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational ALU instance between two requesters, e.g. the integer execute path and a secondary micro-op source. It accepts one operation at a time over a valid/ready handshake and registers the operands that drive the ALU. It then registers the ALU result and returns it on a per-requester valid/ready response channel. The block sits between the requesters and the ALU, and owns all four ALU inputs.

## Interface
- DATA_WIDTH, 32, operand/result width
- FUNC3_WIDTH, 3, func3 width
- FUNC7_WIDTH, 7, func7 width
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- reqN_valid  input  1  requester N (N=0,1) has an operation
- reqN_ready  output  1  arbiter accepts requester N's operation this cycle
- reqN_a, reqN_b  input  DATA_WIDTH  operands, forwarded unchanged to the ALU A/B inputs
- reqN_func3  input  FUNC3_WIDTH  ALU func3
- reqN_func7  input  FUNC7_WIDTH  ALU func7
- rspN_valid  output  1  result for requester N available
- rspN_ready  input  1  requester N takes the result
- rspN_data  output  DATA_WIDTH  result
- alu_bus_A, alu_bus_B  output  DATA_WIDTH  to ALU operand inputs
- alu_func3  output  FUNC3_WIDTH  to ALU
- alu_func7  output  FUNC7_WIDTH  to ALU
- alu_bus_out  input  DATA_WIDTH  ALU result (combinational)
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If no reqN_valid is high, stay in IDLE.
  - Otherwise choose a winner W:
    - Only one valid: that requester wins.
    - Both valid: the requester other than last_grant wins.
  - reqW_ready=1 (combinational from reqN_valid and last_grant); the other ready=0.
  - At the clock edge: capture reqW_a/b/func3/func7 into the operand registers, store owner=W, last_grant=W, and go to EXEC.
- EXEC:
  - The ALU is driven from the operand registers.
  - At the clock edge: result_reg <= alu_bus_out, go to RESP.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_data=result_reg. The other rsp_valid=0.
  - Stay in RESP until rsp[owner]_ready=1, then go to IDLE at that edge.
- reqN_ready is 0 in EXEC and RESP. No new accept occurs in the same cycle as a response handshake.
- ALU outputs always equal the operand registers, which hold their value outside the capture edge. This keeps ALU inputs stable for a full cycle.
- rspN_data is driven with result_reg for both N. Only rspN_valid qualifies it.
- No arithmetic is performed in this block. Widths pass through unchanged.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first contention).
  - owner=0, operand registers=0, func fields=0, result_reg=0.
  - All rspN_valid=0, busy=0.
  - reqN_ready follows IDLE logic, so it is 0 while no reqN_valid is high.
- Reset mid-operation: any captured operation or pending result is discarded, with no response issued. The FSM returns to IDLE immediately (asynchronous).

## Timing
- Accept edge k: the reqW_valid & reqW_ready cycle ends at edge k.
- Cycle k→k+1: EXEC; ALU inputs equal the captured values.
- Edge k+1: result registered; rspW_valid rises after edge k+1.
- Minimum latency is 2 cycles from accept to rsp_valid.
- Minimum issue interval is 3 cycles: IDLE, EXEC, RESP with rsp_ready already high.
- A backpressured response (rsp_ready=0) holds RESP, valid and data indefinitely. Data stays stable while valid.
- Combinational paths:
  - reqN_valid → reqN_ready.
  - alu_bus_out → result_reg D-input only (no input-to-output path).
- A requester deasserting valid before being granted is legal; nothing is captured for it.

## Test plan
- Single op: req0 a=5, b=3, func3=000, func7=0, ALU model computes A+B → req0_ready=1 in the IDLE cycle; rsp0_valid rises 2 cycles after accept with data=8; rsp1_valid stays 0.
- Contention from reset: req0 and req1 valid together, continuously, rsp ready tied high → grants alternate 0,1,0,1; each rsp goes only to its owner; one accept every 3 cycles.
- Backpressure: rsp1_ready=0 for 10 cycles after rsp1_valid → rsp1_valid and data held, busy=1, req0_ready=0 throughout; release → IDLE next cycle, then req0 is accepted.
- Operand stability: change req0_a/func3 during EXEC and RESP → alu_bus_A/alu_func3 stay at the captured values until the next accept.
- Reset mid-op: assert rst during EXEC, and again during RESP → busy and rspN_valid drop to 0 immediately; ALU outputs=0; after release, a new req0 is accepted normally, requester 0 winning any contention.
- Solo requester fairness: only req1 valid for 3 back-to-back ops → all granted to req1 without idle gaps beyond the 3-cycle interval.
